// File: rtl/data_demux_4ch_if.sv
// Handshake bundle between the result producer and the 4-channel demux.
// The out_count bus and CNT_W exist only when DEMUX_COUNT_EN is defined.
interface data_demux_4ch_if #(
    parameter int WIDTH = 32
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
`ifdef DEMUX_COUNT_EN
    logic [4*CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
`else
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/data_demux_4ch.sv
// 1-to-4 result demux with a one-entry valid/ready register per destination channel.
// Per-channel delivery counters are built only when DEMUX_COUNT_EN is defined.
module data_demux_4ch #(
    parameter int WIDTH = 32
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    data_demux_4ch_if.slave bus
);
    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [4];
    logic             w_accept;
    logic [3:0]       w_load;
    logic [3:0]       w_xfer;

    // Only the addressed channel can stall the input; reset holds it closed.
    assign bus.in_ready = !reset && (!r_valid[bus.in_sel] || bus.out_ready[bus.in_sel]);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_xfer       = r_valid & bus.out_ready;

    always_comb begin
        w_load = 4'b0000; // NOTE: default before the conditional write, otherwise a latch is inferred
        if (w_accept) begin
            w_load[bus.in_sel] = 1'b1;
        end
    end

    // A load wins over a drain on the same channel: pass-through refill with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 4'b0000; // NOTE: non-blocking for all sequential state to avoid ordering races
            for (int n = 0; n < 4; n++) begin
                r_data[n] <= '0; // NOTE: the data registers are reset because their value is visible on out_data
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_load[n]) begin
                    r_valid[n] <= 1'b1;
                    r_data[n]  <= bus.in_data;
                end else if (w_xfer[n]) begin
                    r_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = r_valid;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign bus.out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] r_count [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                r_count[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_xfer[n]) begin
                    r_count[n] <= r_count[n] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign bus.out_count[g*CNT_W +: CNT_W] = r_count[g];
    end
`endif

endmodule

// File: tb/tb_data_demux_4ch.sv
// Directed self-checking bench for data_demux_4ch; define DEMUX_COUNT_EN to also
// exercise the per-channel delivery counters including the 0xFFFF wrap.
module tb_data_demux_4ch;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    data_demux_4ch_if u_if ();

    data_demux_4ch u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ch_data(input int n);
        return u_if.out_data[n*32 +: 32];
    endfunction

`ifdef DEMUX_COUNT_EN
    function automatic logic [15:0] ch_count(input int n);
        return u_if.out_count[n*16 +: 16];
    endfunction
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset            = 1'b1;
        u_if.in_valid    = 1'b0;
        u_if.in_data     = '0;
        u_if.in_sel      = 2'd0;
        u_if.out_ready   = 4'b1111;
        tick();
        tick();
        check("in_ready_in_reset", u_if.in_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_out_valid", u_if.out_valid, 4'b0000);
        check("rst_out_data", u_if.out_data, 128'h0);
        for (int s = 0; s < 4; s++) begin
            u_if.in_sel = s[1:0];
            #1;
            check($sformatf("rst_in_ready_sel%0d", s), u_if.in_ready, 1'b1);
        end
`ifdef DEMUX_COUNT_EN
        check("rst_counts", u_if.out_count, 64'h0);
`endif

        // Single word to ch2.
        u_if.in_sel   = 2'd2;
        u_if.in_data  = 32'hDEADBEEF;
        u_if.in_valid = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        check("single_valid", u_if.out_valid, 4'b0100);
        check("single_data", ch_data(2), 32'hDEADBEEF);
        tick();
        check("single_drained", u_if.out_valid, 4'b0000);
`ifdef DEMUX_COUNT_EN
        check("single_count2", ch_count(2), 16'd1);
`endif

        // Back-pressure on ch1.
        u_if.out_ready = 4'b1101;
        u_if.in_sel    = 2'd1;
        u_if.in_data   = 32'h11;
        u_if.in_valid  = 1'b1;
        #1;
        check("bp_ready_first", u_if.in_ready, 1'b1);
        tick();
        u_if.in_data = 32'h22;
        #1;
        check("bp_ready_stalled", u_if.in_ready, 1'b0);
        check("bp_valid_held", u_if.out_valid, 4'b0010);
        check("bp_data_held", ch_data(1), 32'h11);
        tick();
        check("bp_valid_stable", u_if.out_valid, 4'b0010);
        check("bp_data_stable", ch_data(1), 32'h11);
        u_if.out_ready = 4'b1111;
        #1;
        check("bp_ready_release", u_if.in_ready, 1'b1);
        tick();
        u_if.in_valid = 1'b0;
        check("bp_refill_valid", u_if.out_valid, 4'b0010);
        check("bp_refill_data", ch_data(1), 32'h22);
        tick();
        check("bp_drained", u_if.out_valid, 4'b0000);
`ifdef DEMUX_COUNT_EN
        check("bp_count1", ch_count(1), 16'd2);
`endif

        // ch0 full and stalled while ch3 streams.
        u_if.out_ready = 4'b1110;
        u_if.in_sel    = 2'd0;
        u_if.in_data   = 32'h77;
        u_if.in_valid  = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            u_if.in_sel  = 2'd3;
            u_if.in_data = 32'hA0 + i;
            #1;
            check($sformatf("iso_ready_%0d", i), u_if.in_ready, 1'b1);
            tick();
            check($sformatf("iso_valid_%0d", i), u_if.out_valid, 4'b1001);
            check($sformatf("iso_ch3_%0d", i), ch_data(3), 32'hA0 + i);
            check($sformatf("iso_ch0_%0d", i), ch_data(0), 32'h77);
        end
        u_if.in_sel = 2'd0;
        #1;
        check("iso_ch0_full_ready", u_if.in_ready, 1'b0);
        u_if.in_valid = 1'b0;
        tick();
        check("iso_ch3_drained", u_if.out_valid, 4'b0001);

        // Continuous stream to ch0; first beat also drains the held 0x77.
        u_if.out_ready = 4'b1111;
        u_if.in_sel    = 2'd0;
        u_if.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            u_if.in_data = i;
            #1;
            check($sformatf("stream_ready_%0d", i), u_if.in_ready, 1'b1);
            tick();
            check($sformatf("stream_valid_%0d", i), u_if.out_valid, 4'b0001);
            check($sformatf("stream_data_%0d", i), ch_data(0), i);
        end
        u_if.in_valid = 1'b0;
        tick();
        check("stream_drained", u_if.out_valid, 4'b0000);
`ifdef DEMUX_COUNT_EN
        check("stream_count0", ch_count(0), 16'd9);
`endif

        // Reset while ch2 holds a stalled word.
        u_if.out_ready = 4'b1011;
        u_if.in_sel    = 2'd2;
        u_if.in_data   = 32'h55;
        u_if.in_valid  = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        check("rst_mid_held", u_if.out_valid, 4'b0100);
        reset = 1'b1;
        #1;
        check("rst_mid_in_ready", u_if.in_ready, 1'b0);
        tick();
        reset = 1'b0;
        check("rst_mid_valid", u_if.out_valid, 4'b0000);
        check("rst_mid_ch2", ch_data(2), 32'h0);
        u_if.out_ready = 4'b1111;
        tick();
        check("rst_mid_no_delivery", u_if.out_valid, 4'b0000);
`ifdef DEMUX_COUNT_EN
        check("rst_mid_counts", u_if.out_count, 64'h0);

        // Drive count1 to 0xFFFF, then one more delivery wraps it.
        u_if.in_sel   = 2'd1;
        u_if.in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            u_if.in_data = i;
            tick();
        end
        u_if.in_valid = 1'b0;
        tick();
        check("wrap_count_max", ch_count(1), 16'hFFFF);
        u_if.in_valid = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        tick();
        check("wrap_count_zero", ch_count(1), 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_demux_4ch.md
Name: data_demux_4ch

Overview:
- Write-side counterpart of the datapath's 4-channel data select: takes one 32-bit result stream and delivers each word to one of four destination channels chosen by a 2-bit select.
- Each channel has a one-entry output register with a valid/ready handshake, so a stalled consumer (e.g. register-file write port, memory store path, HI/LO) back-pressures only the traffic aimed at it.
- Sits between the execute/writeback result path and the four data consumers.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of per-channel delivery counters (used only with DEMUX_COUNT_EN).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  demux can accept the input word this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  2  destination channel, 0..3; 2'b00 = ch0, 2'b01 = ch1, 2'b10 = ch2, 2'b11 = ch3.
- out_valid  out  4  per-channel output valid, bit n = channel n.
- out_ready  in  4  per-channel consumer ready, bit n = channel n.
- out_data  out  4*WIDTH  packed channel data; channel n at bits [n*WIDTH +: WIDTH].
- out_count  out  4*CNT_W  packed per-channel delivery counts; present only with DEMUX_COUNT_EN.

Behaviour:
- Reset (synchronous, active-high): out_valid = 4'b0000, all out_data = 0, all counters = 0. Reset wins over any simultaneous transfer. Reset asserted mid-stall discards the held words; no delivery is reported for them.
- Accept condition: input transfer when in_valid && in_ready at a rising edge.
- in_ready = !out_valid[in_sel] || out_ready[in_sel]. This is combinational from in_sel, out_valid and out_ready. It does not depend on in_valid, and it is 0 while reset is high.
- Channel n output transfer: out_valid[n] && out_ready[n] at a rising edge.
- Per-channel register update, evaluated independently for each n:
  - Input accepted with in_sel == n: out_data[n] <= in_data, out_valid[n] <= 1. This holds even if channel n transfers in the same cycle (pass-through refill, no bubble).
  - Otherwise, if channel n transfers: out_valid[n] <= 0; out_data[n] holds its last value.
  - Otherwise: hold.
- Latency: exactly 1 cycle from input accept to out_valid on the target channel.
- Throughput: one word per cycle into any single channel whose consumer keeps out_ready high.
- Stability: while out_valid[n] && !out_ready[n], out_data[n] and out_valid[n] must not change.
- Only the channel selected by in_sel is affected by an input transfer. Other channels continue draining in the same cycle.
- Full channel: when channel n is full and not draining, an input aimed at n is stalled (in_ready = 0). Upstream holds in_data and in_sel. The block never drops or duplicates a word.
- No ordering guarantee across channels. Words sent to the same channel are delivered in acceptance order.
- out_valid bits never go X after reset; out_ready is ignored for invalid channels.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - out_count port exists.
  - Counter n increments by 1 on each channel-n output transfer and wraps modulo 2^CNT_W (0xFFFF -> 0x0000 at the default).
  - Reset clears all counters.
  - The count is visible the cycle after the transfer.
- Undefined: out_count port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset with all out_ready = 1 -> out_valid = 0000, out_data all 0, in_ready = 1 for every in_sel; with DEMUX_COUNT_EN, all counts 0.
- in_data = 0xDEADBEEF, in_sel = 2, in_valid one cycle, out_ready = 1111 -> next cycle out_valid = 0100, ch2 data = 0xDEADBEEF; cycle after, out_valid = 0000, count2 = 1.
- out_ready[1] = 0; send 0x11 then 0x22 to ch1 -> first accepted; second sees in_ready = 0 and ch1 holds 0x11 stable; raise out_ready[1] -> 0x11 delivered, 0x22 accepted the same cycle and delivered next cycle; no loss.
- ch0 stalled full (out_ready[0] = 0) while 0xA0, 0xA1, 0xA2 go to ch3 back-to-back -> ch3 delivers all three consecutively with one-cycle latency; ch0 data unchanged throughout.
- Continuous stream 0..7 to ch0 with out_ready[0] = 1 -> in_ready stays 1, outputs 0..7 on consecutive cycles, no bubbles.
- ch2 holding 0x55 stalled, assert reset one cycle -> out_valid = 0000, ch2 data = 0, in_ready = 0 during reset, 0x55 never delivered. With the counter preset at 0xFFFF, one ch1 delivery -> count1 = 0x0000.
